// File: rtl/branch_resolver.sv
// EX-stage branch resolver: queues fetch-side predictions, resolves them in order
// against the real outcome and returns registered update/flush feedback.
module branch_resolver #(
    parameter int Q_SIZE  = 2,
    parameter int CNT_WID = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               push,
    input  logic [31:0]        push_pc,
    input  logic               push_taken,
    input  logic [31:0]        push_target,
    input  logic               push_cond,
    input  logic               ex_valid,
    input  logic [2:0]         ex_funct3,
    input  logic [31:0]        ex_src1,
    input  logic [31:0]        ex_src2,
    input  logic [31:0]        ex_target,
    output logic               full,
    output logic               empty,
    output logic               old_branch,
    output logic [31:0]        old_branch_pc,
    output logic               old_predict,
    output logic               old_actual,
    output logic [31:0]        old_predict_pc,
    output logic [31:0]        old_pc,
    output logic               flush,
    output logic               q_err,
    output logic [CNT_WID-1:0] br_cnt,
    output logic [CNT_WID-1:0] miss_cnt
);
    localparam int DEPTH = 1 << Q_SIZE;
    localparam int CW    = Q_SIZE + 1;
    localparam logic [CW-1:0]      CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      CNT_ZERO = CW'(0);
    localparam logic [Q_SIZE-1:0]  PTR_ONE  = Q_SIZE'(1);
    localparam logic [Q_SIZE-1:0]  PTR_ZERO = Q_SIZE'(0);
    localparam logic [CNT_WID-1:0] STAT_MAX = {CNT_WID{1'b1}};
    localparam logic [CNT_WID-1:0] STAT_ONE = CNT_WID'(1);

    function automatic logic resolve_taken(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b, input logic cond);
        logic t;
        if (!cond) begin
            t = 1'b1;
        end else begin
            case (f3)
                3'b000:  t = (a == b);
                3'b001:  t = (a != b);
                3'b100:  t = ($signed(a) <  $signed(b));
                3'b101:  t = ($signed(a) >= $signed(b));
                3'b110:  t = (a <  b);
                3'b111:  t = (a >= b);
                default: t = 1'b0;
            endcase
        end
        return t;
    endfunction

    logic [31:0]       pc_q_r     [DEPTH];
    logic              taken_q_r  [DEPTH];
    logic [31:0]       target_q_r [DEPTH];
    logic              cond_q_r   [DEPTH];
    logic [Q_SIZE-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]     count_r, cnt_nxt_s;

    logic        full_s, empty_s, pop_s, push_ok_s, flush_q_s, err_s;
    logic        actual_s, miss_s;
    logic [31:0] head_pc_s, head_target_s, actual_next_s;
    logic        head_taken_s, head_cond_s;

    assign full_s        = (count_r == CNT_FULL);
    assign empty_s       = (count_r == CNT_ZERO);
    assign head_pc_s     = pc_q_r[rd_ptr_r];
    assign head_taken_s  = taken_q_r[rd_ptr_r];
    assign head_target_s = target_q_r[rd_ptr_r];
    assign head_cond_s   = cond_q_r[rd_ptr_r];

    // Resolve the head entry and decide what the queue does this cycle.
    always_comb begin
        actual_s      = resolve_taken(ex_funct3, ex_src1, ex_src2, head_cond_s);
        actual_next_s = actual_s ? ex_target : (head_pc_s + 32'd4);
        miss_s        = (actual_next_s != head_target_s);
        pop_s         = ex_valid && !stall && !empty_s;
        flush_q_s     = pop_s && miss_s;
        // A mispredict makes any same-cycle push wrong-path, so it is silently dropped.
        push_ok_s     = push && !stall && (!full_s || pop_s) && !flush_q_s;
        err_s         = !stall && ((push && full_s && !pop_s) || (ex_valid && empty_s));
        if (flush_q_s) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (push_ok_s && !pop_s) begin
            cnt_nxt_s = count_r + CNT_ONE;
        end else if (!push_ok_s && pop_s) begin
            cnt_nxt_s = count_r - CNT_ONE;
        end else begin
            cnt_nxt_s = count_r;
        end
    end

    // Queue pointers, occupancy and full/empty flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (flush_q_s) begin
                wr_ptr_r <= PTR_ZERO;
                rd_ptr_r <= PTR_ZERO;
            end else begin
                if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
                if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= cnt_nxt_s;
            full    <= (cnt_nxt_s == CNT_FULL);
            empty   <= (cnt_nxt_s == CNT_ZERO);
        end
    end

    // Prediction storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q_r[i]     <= 32'd0;
                taken_q_r[i]  <= 1'b0;
                target_q_r[i] <= 32'd0;
                cond_q_r[i]   <= 1'b0;
            end
        end else if (push_ok_s) begin
            pc_q_r[wr_ptr_r]     <= push_pc;
            taken_q_r[wr_ptr_r]  <= push_taken;
            target_q_r[wr_ptr_r] <= push_target;
            cond_q_r[wr_ptr_r]   <= push_cond;
        end
    end

    // Registered feedback, sticky error and saturating statistics; all frozen by stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            old_branch     <= 1'b0;
            old_branch_pc  <= 32'd0;
            old_predict    <= 1'b0;
            old_actual     <= 1'b0;
            old_predict_pc <= 32'd0;
            old_pc         <= 32'd0;
            flush          <= 1'b0;
            q_err          <= 1'b0;
            br_cnt         <= {CNT_WID{1'b0}};
            miss_cnt       <= {CNT_WID{1'b0}};
        end else if (!stall) begin
            old_branch <= pop_s && head_cond_s;
            flush      <= flush_q_s;
            q_err      <= q_err || err_s;
            if (pop_s) begin
                old_branch_pc  <= head_pc_s;
                old_predict    <= head_taken_s;
                old_actual     <= actual_s;
                old_predict_pc <= head_target_s;
                old_pc         <= actual_next_s;
                if (br_cnt != STAT_MAX) br_cnt <= br_cnt + STAT_ONE;
                if (miss_s && (miss_cnt != STAT_MAX)) miss_cnt <= miss_cnt + STAT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: a reference queue model produces the
// expected feedback, which is queued as a scoreboard and compared when it appears.
module tb_branch_resolver;
    logic        clk = 1'b0;
    logic        rst_n, stall, push, push_taken, push_cond, ex_valid;
    logic [31:0] push_pc, push_target, ex_src1, ex_src2, ex_target;
    logic [2:0]  ex_funct3;
    logic        full, empty, old_branch, old_predict, old_actual, flush, q_err;
    logic [31:0] old_branch_pc, old_predict_pc, old_pc, br_cnt, miss_cnt;

    typedef struct packed {
        logic [31:0] pc; logic taken; logic [31:0] target; logic cond;
    } ent_t;
    typedef struct packed {
        logic br; logic [31:0] bpc; logic pred; logic act;
        logic [31:0] ppc; logic [31:0] npc; logic fl;
    } exp_t;

    ent_t        mq[$];
    exp_t        sb[$];
    logic [31:0] m_br, m_miss;
    logic        m_err;
    int          checks = 0, errors = 0;

    branch_resolver #(.Q_SIZE(2), .CNT_WID(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .push(push), .push_pc(push_pc),
        .push_taken(push_taken), .push_target(push_target), .push_cond(push_cond),
        .ex_valid(ex_valid), .ex_funct3(ex_funct3), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_target(ex_target), .full(full), .empty(empty), .old_branch(old_branch),
        .old_branch_pc(old_branch_pc), .old_predict(old_predict), .old_actual(old_actual),
        .old_predict_pc(old_predict_pc), .old_pc(old_pc), .flush(flush), .q_err(q_err),
        .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic model_taken(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b, input logic cond);
        if (!cond) return 1'b1;
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Apply the currently driven inputs to the model, advance one clock, release strobes.
    task automatic tick();
        ent_t h; exp_t e; logic act, miss; logic [31:0] nxt;
        miss = 1'b0;
        if (!stall) begin
            if (ex_valid && mq.size() == 0) m_err = 1'b1;
            if (ex_valid && mq.size() > 0) begin
                h    = mq.pop_front();
                act  = model_taken(ex_funct3, ex_src1, ex_src2, h.cond);
                nxt  = act ? ex_target : h.pc + 32'd4;
                miss = (nxt != h.target);
                e    = '{h.cond, h.pc, h.taken, act, h.target, nxt, miss};
                sb.push_back(e);
                if (m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
                if (miss && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
            end
            if (miss) mq.delete();
            else if (push) begin
                if (mq.size() < 4) mq.push_back('{push_pc, push_taken, push_target, push_cond});
                else m_err = 1'b1;
            end
        end
        @(posedge clk); #1;
        push = 1'b0; ex_valid = 1'b0; stall = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                            input logic c);
        push = 1'b1; push_pc = pc; push_taken = t; push_target = tg; push_cond = c;
    endtask

    task automatic set_ex(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] tg);
        ex_valid = 1'b1; ex_funct3 = f3; ex_src1 = a; ex_src2 = b; ex_target = tg;
    endtask

    task automatic test_reset();
        checks++;
        if ({full, empty, old_branch, flush, q_err, old_pc, br_cnt, miss_cnt} !== {3'b010, 2'b00, 96'd0}) begin
            errors++;
            $display("FAIL reset_state: got full=%b empty=%b ob=%b fl=%b qe=%b pc=%h br=%0d miss=%0d",
                     full, empty, old_branch, flush, q_err, old_pc, br_cnt, miss_cnt);
        end
    endtask

    task automatic test_first_branch();
        exp_t e;
        set_push(32'h100, 1'b1, 32'h140, 1'b1); tick();
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL first_empty: got %b exp 0", empty); end
        set_ex(3'b000, 32'd5, 32'd5, 32'h140); tick();
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if ({old_branch, old_branch_pc, old_predict, old_actual, old_predict_pc, old_pc, flush} !== e) begin
            errors++; $display("FAIL first_sb: got pc=%h old_pc=%h exp %h", old_branch_pc, old_pc, e);
        end
        checks++;
        if ({old_branch, old_actual, old_pc, flush, br_cnt, miss_cnt} !== {2'b11, 32'h140, 1'b0, 32'd1, 32'd0}) begin
            errors++; $display("FAIL first_const: got ob=%b act=%b pc=%h fl=%b br=%0d miss=%0d exp 1 1 140 0 1 0",
                               old_branch, old_actual, old_pc, flush, br_cnt, miss_cnt);
        end
        tick();
        checks++;
        if ({old_branch, old_pc} !== {1'b0, 32'h140}) begin
            errors++; $display("FAIL first_pulse: got ob=%b pc=%h exp 0 140", old_branch, old_pc);
        end
    endtask

    task automatic test_mispredict_flush();
        exp_t e;
        set_push(32'h200, 1'b1, 32'h180, 1'b1); tick();
        set_push(32'h204, 1'b0, 32'h208, 1'b1); tick();
        set_ex(3'b100, 32'd3, 32'hFFFF_FFFF, 32'h180);
        set_push(32'h300, 1'b0, 32'h304, 1'b1);
        tick();
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if ({old_branch, old_branch_pc, old_predict, old_actual, old_predict_pc, old_pc, flush} !== e) begin
            errors++; $display("FAIL flush_sb: got pc=%h old_pc=%h fl=%b exp %h", old_branch_pc, old_pc, flush, e);
        end
        checks++;
        if ({old_actual, old_pc, flush, empty, q_err, miss_cnt} !== {1'b0, 32'h204, 3'b110, 32'd1}) begin
            errors++; $display("FAIL flush_const: got act=%b pc=%h fl=%b empty=%b qe=%b miss=%0d exp 0 204 1 1 0 1",
                               old_actual, old_pc, flush, empty, q_err, miss_cnt);
        end
        tick();
        checks++;
        if ({flush, empty} !== 2'b01) begin errors++; $display("FAIL flush_pulse: got fl=%b empty=%b exp 0 1", flush, empty); end
    endtask

    task automatic test_compare();
        logic [2:0]  f3s [10] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b110, 3'b101, 3'b111, 3'b010, 3'b011, 3'b001};
        logic [31:0] s1s [10] = '{32'd7, 32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd5, 32'd5, 32'd9};
        logic [31:0] s2s [10] = '{32'd7, 32'd8, 32'd7, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd5, 32'd5, 32'd3};
        logic        acts[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] pc;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            pc = 32'h1000 + 32'(i * 16);
            set_push(pc, i[0], i[0] ? pc + 32'h40 : pc + 32'd4, 1'b1); tick();
            set_ex(f3s[i], s1s[i], s2s[i], pc + 32'h40); tick();
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            checks++;
            if ({old_branch, old_branch_pc, old_predict, old_actual, old_predict_pc, old_pc, flush} !== e
                || old_actual !== acts[i]) begin
                errors++; $display("FAIL compare[%0d]: got act=%b pc=%h fl=%b exp act=%b sb=%h",
                                   i, old_actual, old_pc, flush, acts[i], e);
            end
        end
        checks++;
        if ({br_cnt, miss_cnt} !== {m_br, m_miss}) begin
            errors++; $display("FAIL compare_cnt: got br=%0d miss=%0d exp %0d %0d", br_cnt, miss_cnt, m_br, m_miss);
        end
    endtask

    task automatic test_jalr();
        exp_t e;
        set_push(32'h2F0, 1'b1, 32'h300, 1'b0); tick();
        set_ex(3'b000, 32'd1, 32'd2, 32'h308); tick();
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if ({old_branch, old_branch_pc, old_predict, old_actual, old_predict_pc, old_pc, flush} !== e
            || {old_branch, flush, old_pc} !== {2'b01, 32'h308}) begin
            errors++; $display("FAIL jalr: got ob=%b fl=%b pc=%h exp 0 1 308", old_branch, flush, old_pc);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        set_push(32'h500, 1'b0, 32'h504, 1'b1); tick();
        set_ex(3'b010, 32'd0, 32'd0, 32'h540); stall = 1'b1; tick();
        checks++;
        if ({empty, old_branch, br_cnt} !== {2'b00, m_br}) begin
            errors++; $display("FAIL stall_nopop: got empty=%b ob=%b br=%0d exp 0 0 %0d", empty, old_branch, br_cnt, m_br);
        end
        set_ex(3'b010, 32'd0, 32'd0, 32'h540); tick();
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if ({old_branch, old_branch_pc, old_predict, old_actual, old_predict_pc, old_pc, flush} !== e) begin
            errors++; $display("FAIL stall_resolve: got pc=%h ob=%b exp %h", old_branch_pc, old_branch, e);
        end
        stall = 1'b1; tick();
        checks++;
        if (old_branch !== 1'b1) begin errors++; $display("FAIL stall_hold: got ob=%b exp 1", old_branch); end
        tick();
        checks++;
        if (old_branch !== 1'b0) begin errors++; $display("FAIL stall_release: got ob=%b exp 0", old_branch); end
    endtask

    task automatic test_full();
        logic [31:0] order[4] = '{32'h404, 32'h408, 32'h40C, 32'h414};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            set_push(32'h400 + 32'(i * 4), 1'b0, 32'h404 + 32'(i * 4), 1'b1); tick();
        end
        checks++;
        if ({full, q_err} !== 2'b10) begin errors++; $display("FAIL full_set: got full=%b qe=%b exp 1 0", full, q_err); end
        set_push(32'h410, 1'b0, 32'h414, 1'b1); tick();
        checks++;
        if ({full, q_err} !== {1'b1, m_err}) begin errors++; $display("FAIL full_drop: got full=%b qe=%b exp 1 1", full, q_err); end
        set_push(32'h414, 1'b0, 32'h418, 1'b1); set_ex(3'b010, 32'd0, 32'd0, 32'h0); tick();
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if ({full, old_branch_pc, flush} !== {1'b1, 32'h400, 1'b0} || old_branch_pc !== e.bpc) begin
            errors++; $display("FAIL full_pushpop: got full=%b pc=%h fl=%b exp 1 400 0", full, old_branch_pc, flush);
        end
        for (int i = 0; i < 4; i++) begin
            set_ex(3'b010, 32'd0, 32'd0, 32'h0); tick();
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            checks++;
            if ({old_branch, old_branch_pc, old_predict, old_actual, old_predict_pc, old_pc, flush} !== e
                || old_branch_pc !== order[i]) begin
                errors++; $display("FAIL full_order[%0d]: got pc=%h exp %h", i, old_branch_pc, order[i]);
            end
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL full_drain: got empty=%b exp 1", empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_push(32'h600 + 32'(i * 4), 1'b1, 32'h700, 1'b1); tick();
        end
        rst_n = 1'b0; #2;
        checks++;
        if ({full, empty, old_branch, flush, q_err, old_pc, old_branch_pc, br_cnt, miss_cnt} !== {3'b010, 2'b00, 128'd0}) begin
            errors++; $display("FAIL reset_mid: got full=%b empty=%b qe=%b pc=%h br=%0d miss=%0d exp all clear",
                               full, empty, q_err, old_pc, br_cnt, miss_cnt);
        end
        mq.delete(); sb.delete(); m_br = 32'd0; m_miss = 32'd0; m_err = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_empty_pop();
        set_ex(3'b000, 32'd1, 32'd1, 32'h10); tick();
        checks++;
        if ({old_branch, flush, q_err, br_cnt} !== {2'b00, m_err, 32'd0} || sb.size() != 0) begin
            errors++; $display("FAIL empty_pop: got ob=%b fl=%b qe=%b br=%0d exp 0 0 1 0", old_branch, flush, q_err, br_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; push = 1'b0; push_pc = 32'd0; push_taken = 1'b0;
        push_target = 32'd0; push_cond = 1'b0; ex_valid = 1'b0; ex_funct3 = 3'd0;
        ex_src1 = 32'd0; ex_src2 = 32'd0; ex_target = 32'd0;
        m_br = 32'd0; m_miss = 32'd0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_first_branch();
        test_mispredict_flush();
        test_compare();
        test_jalr();
        test_stall();
        test_full();
        test_reset_mid();
        test_empty_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
